// File: rtl/ftm_trace_packer.sv
// Multi-channel FTM trace source: per-channel FIFOs, round-robin
// arbitration and LSB-first serialisation into 32-bit ATID-tagged beats.
module ftm_trace_packer #(
    parameter int N_CH         = 4,
    parameter int DATA_W       = 64,
    parameter int FIFO_DEPTH   = 8,
    parameter int ATID_BASE    = 1,
    parameter bit DROP_ON_FULL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trace_en,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    output logic [N_CH-1:0]          ch_ready,
    output logic [N_CH*16-1:0]       drop_cnt,
    output logic [31:0]              trace_data,
    output logic [3:0]               trace_atid,
    output logic                     trace_valid,
    output logic                     trace_clock
);

    localparam int BEATS = DATA_W / 32;
    localparam int PW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    localparam logic [PW-1:0] PTR_RST   = PW'(N_CH - 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    logic [N_CH-1:0]        full;
    logic [N_CH-1:0]        elig;
    logic [N_CH-1:0]        push;
    logic [N_CH-1:0]        pop;
    logic [N_CH*DATA_W-1:0] heads;

    state_t                 state_q;
    logic [BW-1:0]          beat_q;
    logic [PW-1:0]          ptr_q;
    logic [DATA_W-1:0]      word_q;
    logic                   valid_q;
    logic [31:0]            data_q;
    logic [3:0]             atid_q;

    logic                   gnt_vld;
    logic [PW-1:0]          gnt_idx;
    logic                   can_start;
    logic                   do_grant;
    logic [DATA_W-1:0]      head_sel;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]     wr_ptr_q;
        logic [AW-1:0]     rd_ptr_q;
        logic [CW-1:0]     cnt_q;

        assign full[i]  = (cnt_q == CW'(FIFO_DEPTH));
        assign elig[i]  = (cnt_q != '0);
        assign push[i]  = ch_valid[i] & ~full[i];
        assign pop[i]   = do_grant & (gnt_idx == PW'(i));
        assign heads[i*DATA_W +: DATA_W] = mem_q[rd_ptr_q];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                if (push[i]) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                cnt_q <= cnt_q + CW'(push[i]) - CW'(pop[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (push[i]) begin
                mem_q[wr_ptr_q] <= ch_data[i*DATA_W +: DATA_W];
            end
        end

        if (DROP_ON_FULL) begin : g_drop
            logic [15:0] drop_q;

            // A pop in the same cycle does not make room for this push.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    drop_q <= '0;
                end else if (ch_valid[i] && full[i] &&
                             drop_q != 16'hFFFF) begin
                    drop_q <= drop_q + 16'd1;
                end
            end

            assign drop_cnt[i*16 +: 16] = drop_q;
            assign ch_ready[i]          = 1'b1;
        end else begin : g_bp
            assign drop_cnt[i*16 +: 16] = 16'h0000;
            assign ch_ready[i]          = rst_n & ~full[i];
        end
    end

    // First eligible channel after the last grant, wrapping around.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!gnt_vld && elig[(int'(ptr_q) + k) % N_CH]) begin
                gnt_vld = 1'b1;
                gnt_idx = PW'((int'(ptr_q) + k) % N_CH);
            end
        end
    end

    assign can_start = (state_q == IDLE) ||
                       (beat_q == LAST_BEAT);
    assign do_grant  = can_start & trace_en & gnt_vld;
    assign head_sel  = heads[int'(gnt_idx)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            ptr_q   <= PTR_RST;
            word_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            atid_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    valid_q <= 1'b0;
                end
                SEND: begin
                    valid_q <= 1'b1;
                    data_q  <= word_q[32*int'(beat_q) +: 32];
                    atid_q  <= 4'(ATID_BASE + int'(ptr_q));
                    beat_q  <= beat_q + BW'(1);
                end
            endcase

            if (do_grant) begin
                state_q <= SEND;
                word_q  <= head_sel;
                ptr_q   <= gnt_idx;
                beat_q  <= '0;
            end else if (state_q == SEND && beat_q == LAST_BEAT) begin
                state_q <= IDLE;
            end
        end
    end

    assign trace_valid = valid_q;
    assign trace_data  = data_q;
    assign trace_atid  = atid_q;
    assign trace_clock = clk;

endmodule
